// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: opcodes, datapath width and
// the command word carried through the issue FIFO.
package alu_pkg;

    localparam int ALU_W = 8;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [3:0]       op;
    } alu_cmd_t;

    // Opcodes above OP_XOR still reach the ALU (it computes A-B) but are tagged.
    function automatic logic op_is_supported(input logic [3:0] op);
        return op <= OP_XOR;
    endfunction

    function automatic logic op_is_add(input logic [3:0] op);
        return op == OP_ADD;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with a combinational head read so the ALU sees
// the oldest command in the same cycle it becomes available.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  alu_cmd_t wr_data,
    input  logic     pop,
    output alu_cmd_t head,
    output logic     empty,
    output logic     full
);

    alu_cmd_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Pointers are exactly log2(DEPTH) bits, so they wrap without extra logic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; stale entries are unreachable
    // once the pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// Issue stage in front of the 8-bit ALU: buffers commands, drives the head
// onto the ALU and registers each result with a qualified carry and error tag.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ALU_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    input  logic [3:0]       cmd_op,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [3:0]       alu_sel,
    input  logic [W-1:0]     alu_out,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_data,
    output logic             res_carry,
    output logic             res_err,
    output logic [CNT_W-1:0] op_cnt
);

    alu_cmd_t         wr_cmd;
    alu_cmd_t         head_cmd;
    logic             fifo_empty, fifo_full;
    logic             push, capture, res_fire;

    logic             res_valid_q, res_valid_d;
    logic [W-1:0]     res_data_q,  res_data_d;
    logic             res_carry_q, res_carry_d;
    logic             res_err_q,   res_err_d;
    logic [CNT_W-1:0] op_cnt_q,    op_cnt_d;

    assign wr_cmd = '{a: ALU_W'(cmd_a), b: ALU_W'(cmd_b), op: cmd_op};

    // Ready depends only on registered FIFO state: no bypass when full.
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (wr_cmd),
        .pop     (capture),
        .head    (head_cmd),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign alu_a   = fifo_empty ? '0 : W'(head_cmd.a);
    assign alu_b   = fifo_empty ? '0 : W'(head_cmd.b);
    assign alu_sel = fifo_empty ? '0 : head_cmd.op;

    assign capture  = !fifo_empty && (!res_valid_q || res_ready);
    assign res_fire = res_valid_q && res_ready;

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_carry_d = res_carry_q;
        res_err_d   = res_err_q;
        if (capture) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_out;
            // The ALU always reports the A+B carry; it only means something for ADD.
            res_carry_d = alu_carry && op_is_add(head_cmd.op);
            res_err_d   = !op_is_supported(head_cmd.op);
        end else if (res_fire) begin
            res_valid_d = 1'b0;
        end
        op_cnt_d = res_fire ? op_cnt_q + CNT_W'(1) : op_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
            res_err_q   <= 1'b0;
            op_cnt_q    <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_carry_q <= res_carry_d;
            res_err_q   <= res_err_d;
            op_cnt_q    <= op_cnt_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;
    assign res_err   = res_err_q;
    assign op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Scoreboard bench for alu_cmd_queue: directed scenarios plus a random stream,
// with a behavioural ALU in place of the real datapath.
module tb_alu_cmd_queue;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a, cmd_b;
    logic [3:0]  cmd_op;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_out;
    logic        alu_carry;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic        res_carry;
    logic        res_err;
    logic [15:0] op_cnt;

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic       e;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_cons   = 0;
    bit   stream_done;

    alu_cmd_queue #(.DEPTH(4), .W(8), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_carry (res_carry),
        .res_err   (res_err),
        .op_cnt    (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the downstream ALU.
    logic [8:0] sum9;
    assign sum9      = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_carry = sum9[8];
    always_comb begin
        case (alu_sel)
            4'd0:    alu_out = sum9[7:0];
            4'd2:    alu_out = alu_a & alu_b;
            4'd3:    alu_out = alu_a ^ alu_b;
            default: alu_out = alu_a - alu_b;
        endcase
    end

    function automatic exp_t ref_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        exp_t r;
        int   ai = int'(a);
        int   bi = int'(b);
        r.c = 1'b0;
        r.e = (op > 4'd3);
        case (op)
            4'd0: begin
                r.d = 8'((ai + bi) % 256);
                r.c = (ai + bi) > 255;
            end
            4'd2:    r.d = a & b;
            4'd3:    r.d = a ^ b;
            default: r.d = 8'((ai - bi + 256) % 256);
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Offer one command; the expected result is queued when the handshake is seen.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input exp_t e);
        bit ok = 0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                exp_q.push_back(e);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: cmd_ready stayed 0 for a=%h b=%h op=%h", a, b, op);
        end
    endtask

    // Monitor: compares every consumed result against the scoreboard, checks
    // hold stability under backpressure and tracks the consumed count.
    initial begin
        exp_t       e;
        bit         hold_prev = 0;
        logic [7:0] prev_d;
        logic       prev_c, prev_e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                n_cons    = 0;
                hold_prev = 0;
            end else begin
                if (hold_prev) begin
                    check("hold_valid", 32'(res_valid), 32'd1);
                    check("hold_data", 32'(res_data), 32'(prev_d));
                    check("hold_carry", 32'(res_carry), 32'(prev_c));
                    check("hold_err", 32'(res_err), 32'(prev_e));
                end
                check("op_cnt", 32'(op_cnt), 32'(n_cons & 32'hFFFF));
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_result: got data=%h with nothing expected", res_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data", 32'(res_data), 32'(e.d));
                        check("res_carry", 32'(res_carry), 32'(e.c));
                        check("res_err", 32'(res_err), 32'(e.e));
                        $display("result %0d: data=%h carry=%b err=%b", n_cons, res_data, res_carry, res_err);
                    end
                    n_cons++;
                end
                hold_prev = res_valid && !res_ready;
                prev_d    = res_data;
                prev_c    = res_carry;
                prev_e    = res_err;
            end
        end
    end

    initial begin
        exp_t       e;
        int         k;
        logic [7:0] first_d;
        bit         drained;

        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_a       = '0;
        cmd_b       = '0;
        cmd_op      = '0;
        res_ready   = 1'b1;
        stream_done = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_op_cnt", 32'(op_cnt), 32'd0);
        check("rst_alu_sel", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD with carry and exact one-cycle latency
        send(8'hF0, 8'h20, 4'd0, '{d: 8'h10, c: 1'b1, e: 1'b0});
        @(negedge clk);
        check("lat_not_early", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(res_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("add_op_cnt", 32'(op_cnt), 32'd1);
        @(posedge clk);
        #1;

        // SUB: carry masked even when A+B overflows; illegal opcode tagged
        send(8'h05, 8'h07, 4'd1, '{d: 8'hFE, c: 1'b0, e: 1'b0});
        send(8'hFF, 8'h01, 4'd1, '{d: 8'hFE, c: 1'b0, e: 1'b0});
        send(8'h09, 8'h03, 4'hA, '{d: 8'h06, c: 1'b0, e: 1'b1});
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: offer 6 commands with the consumer stalled
        res_ready = 1'b0;
        k         = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            cmd_a     = 8'h10 + 8'(k);
            cmd_b     = 8'(k + 1);
            cmd_op    = 4'(k % 4);
            cmd_valid = 1'b1;
            @(negedge clk);
            if (cmd_ready) begin
                exp_q.push_back(ref_model(cmd_a, cmd_b, cmd_op));
                k++;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("bp_accepted", 32'(k), 32'd5);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        first_d = 8'h11;
        check("bp_first_held", 32'(res_data), 32'(first_d));
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_drain_valid", 32'(res_valid), (i < 5) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        check("bp_ready_back", 32'(cmd_ready), 32'd1);

        // Reset mid-stream with one result held and three commands pending
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = ref_model(8'(8'h11 * (i + 1)), 8'h01, 4'd0);
            send(8'(8'h11 * (i + 1)), 8'h01, 4'd0, e);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mrst_res_valid", 32'(res_valid), 32'd0);
        check("mrst_res_data", 32'({res_data, res_carry, res_err}), 32'd0);
        check("mrst_op_cnt", 32'(op_cnt), 32'd0);
        check("mrst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n     = 1'b1;
        res_ready = 1'b1;
        #1;
        check("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mrst_no_stale", 32'(res_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random stream with random consumer stalls
        fork
            begin
                logic [7:0] ra, rb;
                logic [3:0] rop;
                for (int n = 0; n < 1000; n++) begin
                    ra  = 8'($urandom_range(0, 255));
                    rb  = 8'($urandom_range(0, 255));
                    rop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
                    send(ra, rb, rop, ref_model(ra, rb, rop));
                end
                stream_done = 1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    res_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        res_ready = 1'b1;
        drained   = 0;
        for (int i = 0; i < 200 && !drained; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !res_valid) drained = 1;
        end
        if (!drained) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d results still outstanding", exp_q.size());
        end
        check("stream_op_cnt", 32'(op_cnt), 32'd1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
